// File: rtl/nibble_pkg.sv
// Shared opcodes, ALU codes and sequencer state encoding for the nibble processor control path.
package nibble_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  // Opcodes that touch data memory at address k after decode.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/nibble_pc.sv
// Program counter: clear beats load beats increment; increment wraps modulo 2**ADDR_W.
module nibble_pc #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_d,
  output logic [ADDR_W-1:0] o_q
);

  logic [ADDR_W-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_pc <= '0;
    else if (i_clr) r_pc <= '0;
    else if (i_ld)  r_pc <= i_d;
    else if (i_inc) r_pc <= r_pc + ADDR_W'(1);
  end

  assign o_q = r_pc;

endmodule

// File: rtl/nibble_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit nibble datapath with a
// wait-state-tolerant single-port memory handshake, halt and sticky illegal-opcode reporting.
module nibble_seq_ctrl
  import nibble_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] acc_q,
  input  logic              acc_zero,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_b,
  output logic              acc_we,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted,
  output logic              error
);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_opnd;
  logic              r_error;

  logic [3:0]        w_op;
  logic [3:0]        w_k;
  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_clr, w_pc_ld, w_pc_inc;
  logic              w_ir_ld, w_opnd_ld, w_err_set, w_err_clr;

  assign w_op = r_ir[7:4];
  assign w_k  = r_ir[3:0];

  nibble_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_pc_clr),
    .i_ld  (w_pc_ld),
    .i_inc (w_pc_inc),
    .i_d   (ADDR_W'(w_k)),
    .o_q   (w_pc)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_op    = ALU_PASS;
    alu_b     = '0;
    acc_we    = 1'b0;
    w_pc_clr  = 1'b0;
    w_pc_ld   = 1'b0;
    w_pc_inc  = 1'b0;
    w_ir_ld   = 1'b0;
    w_opnd_ld = 1'b0;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next    = S_FETCH;
          w_pc_clr  = 1'b1;
          w_err_clr = 1'b1;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = w_pc;
        if (mem_ready) begin
          w_ir_ld  = 1'b1;
          w_pc_inc = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_op == OP_NOP)                         w_next = S_FETCH;
        else if (is_mem_op(w_op))                   w_next = S_MEM;
        else if (w_op inside {OP_LDI, OP_JMP, OP_JZ}) w_next = S_EXEC;
        else begin
          // HALT opcode stops cleanly; everything else in 8..E is illegal.
          w_next    = S_HALT;
          w_err_set = (w_op != OP_HALT);
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = ADDR_W'(w_k);
        mem_we    = (w_op == OP_ST);
        mem_wdata = (w_op == OP_ST) ? acc_q : '0;
        if (mem_ready) begin
          if (w_op == OP_ST) begin
            w_next = S_FETCH;
          end else begin
            w_opnd_ld = 1'b1;
            w_next    = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          OP_LDI: begin acc_we = 1'b1; alu_op = ALU_PASS; alu_b = DATA_W'(w_k); end
          OP_ADD: begin acc_we = 1'b1; alu_op = ALU_ADD;  alu_b = r_opnd;       end
          OP_SUB: begin acc_we = 1'b1; alu_op = ALU_SUB;  alu_b = r_opnd;       end
          OP_LD:  begin acc_we = 1'b1; alu_op = ALU_PASS; alu_b = r_opnd;       end
          OP_JMP: w_pc_ld = 1'b1;
          OP_JZ:  w_pc_ld = acc_zero;
          default: ;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_opnd  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld)   r_ir   <= mem_rdata;
      if (w_opnd_ld) r_opnd <= mem_rdata[DATA_W-1:0];
      if (w_err_clr)      r_error <= 1'b0;
      else if (w_err_set) r_error <= 1'b1;
    end
  end

  assign pc_o   = w_pc;
  assign halted = (r_state == S_HALT);
  assign error  = r_error;

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Directed bench for nibble_seq_ctrl: memory/accumulator models plus scoreboards of expected
// bus accesses and accumulator strobes.
module tb_nibble_seq_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mem_req, mem_we, acc_we, halted, error;
  logic [AW-1:0] mem_addr, pc_o;
  logic [DW-1:0] mem_wdata, alu_b;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] acc_q;
  logic          acc_zero;
  logic [1:0]    alu_op;

  nibble_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .acc_q(acc_q), .acc_zero(acc_zero),
    .alu_op(alu_op), .alu_b(alu_b), .acc_we(acc_we),
    .pc_o(pc_o), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] addr; logic we; logic [3:0] wdata; } access_t;
  typedef struct packed { logic [1:0] op; logic [3:0] b; } alu_t;

  access_t    q_acc[$];
  alu_t       q_alu[$];
  logic [7:0] mem [16];
  int         waits = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Accumulator of the datapath, with a bench-side preset.
  logic [DW-1:0] acc = '0;
  logic          acc_load = 1'b0;
  logic [DW-1:0] acc_load_val = '0;
  always @(posedge clk) begin
    if (acc_load) acc <= acc_load_val;
    else if (acc_we)
      case (alu_op)
        2'b00:   acc <= alu_b;
        2'b01:   acc <= acc + alu_b;
        2'b10:   acc <= acc - alu_b;
        default: acc <= acc;
      endcase
  end
  assign acc_q    = acc;
  assign acc_zero = (acc == '0);

  // Memory responder: `waits` low-ready cycles per access, then one ready cycle.
  int            wcnt = 0;
  logic          in_wait = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata;
  always @(negedge clk) begin
    if (reset) begin
      wcnt = 0; in_wait = 1'b0; mem_ready = 1'b0;
    end else begin
      if (mem_ready) wcnt = 0;
      if (mem_req) begin
        if (in_wait) begin
          check("hold_addr", mem_addr, h_addr);
          check("hold_we", mem_we, h_we);
          check("hold_wdata", mem_wdata, h_wdata);
        end
        if (wcnt >= waits) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          in_wait   = 1'b0;
          check("acc_expected", q_acc.size() != 0, 1);
          if (q_acc.size() != 0) begin
            access_t e;
            e = q_acc.pop_front();
            check("acc_addr", mem_addr, e.addr);
            check("acc_we", mem_we, e.we);
            if (e.we) check("acc_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) mem[mem_addr] = {4'h0, mem_wdata};
        end else begin
          mem_ready = 1'b0;
          wcnt++;
          in_wait = 1'b1;
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end
      end else begin
        mem_ready = 1'b0;
        in_wait   = 1'b0;
      end
    end
  end

  // Strobe monitor: acc_we matches the scoreboard, never back-to-back; HALT drives no bus request.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (acc_we) begin
        check("we_not_consecutive", prev_we, 0);
        check("alu_expected", q_alu.size() != 0, 1);
        if (q_alu.size() != 0) begin
          alu_t e;
          e = q_alu.pop_front();
          check("alu_op", alu_op, e.op);
          check("alu_b", alu_b, e.b);
        end
      end
      if (halted) check("halt_no_req", mem_req, 0);
      prev_we = acc_we;
    end else prev_we = 1'b0;
  end

  task automatic rd(input logic [3:0] a);
    q_acc.push_back('{addr: a, we: 1'b0, wdata: 4'h0});
  endtask
  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    q_acc.push_back('{addr: a, we: 1'b1, wdata: d});
  endtask
  task automatic strobe(input logic [1:0] op, input logic [3:0] b);
    q_alu.push_back('{op: op, b: b});
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Pulse start, check the restart state, run to HALT and check cycle count / PC / error.
  task automatic go(input string tag, input int wt, input int exp_cyc,
                    input logic [3:0] exp_pc, input logic exp_err);
    int cyc;
    waits = wt;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_start_pc"}, pc_o, 0);
    check({tag, "_start_err"}, error, 0);
    check({tag, "_start_req"}, mem_req, 1);
    check({tag, "_start_addr"}, mem_addr, 0);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_halted"}, halted, 1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_pc"}, pc_o, exp_pc);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_acc_left"}, q_acc.size(), 0);
    check({tag, "_alu_left"}, q_alu.size(), 0);
    q_acc.delete();
    q_alu.delete();
  endtask

  initial begin
    clear_mem();
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_acc_we", acc_we, 0);
    check("rst_pc", pc_o, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset while a fetch is stalled drops the request immediately and returns to IDLE.
    mem[0] = 8'h13;
    waits  = 3;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("mid_req_before", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_req", mem_req, 0);
    check("mid_pc", pc_o, 0);
    check("mid_halted", halted, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_req", mem_req, 0);
    end

    // LDI 3; ADD M[3] (=4); HALT -- zero and two wait states.
    for (int w = 0; w <= 2; w += 2) begin
      clear_mem();
      mem[0] = 8'h13; mem[1] = 8'h23; mem[2] = 8'hF0; mem[3] = 8'h04;
      rd(0); rd(1); rd(3); rd(2);
      strobe(2'b00, 4'd3); strobe(2'b01, 4'd4);
      go(w == 0 ? "add0" : "add2", w, 9 + 4 * w, 4'd3, 1'b0);
      check("add_acc", acc, 7);
    end

    // JZ taken when the accumulator is zero.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h75; mem[2] = 8'hF0; mem[5] = 8'hF0;
    rd(0); rd(1); rd(5);
    strobe(2'b00, 4'd0);
    go("jz_taken", 0, 8, 4'd6, 1'b0);

    // JZ falls through when the accumulator is non-zero.
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h75; mem[2] = 8'hF0; mem[5] = 8'hF0;
    rd(0); rd(1); rd(2);
    strobe(2'b00, 4'd1);
    go("jz_not", 0, 8, 4'd3, 1'b0);

    // Illegal opcode 0x9 halts with sticky error; restart clears it.
    clear_mem();
    mem[0] = 8'h13; mem[1] = 8'h95;
    rd(0); rd(1);
    strobe(2'b00, 4'd3);
    go("illegal", 0, 5, 4'd2, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("illegal_hold_err", error, 1);
    end
    mem[0] = 8'hF0;
    rd(0);
    go("restart", 0, 2, 4'd1, 1'b0);

    // Store then wrap: JZ 13 (not taken), LDI 7, ST A, LDI 0, JMP F, NOP at 15 -> fetch 0, JZ 13 taken.
    clear_mem();
    mem[0] = 8'h7D; mem[1] = 8'h17; mem[2] = 8'h5A; mem[3] = 8'h10;
    mem[4] = 8'h6F; mem[15] = 8'h00; mem[13] = 8'hF0;
    @(negedge clk) begin acc_load = 1'b1; acc_load_val = 4'd1; end
    @(negedge clk) acc_load = 1'b0;
    rd(0); rd(1); rd(2); wr(4'hA, 4'd7); rd(3); rd(4); rd(15); rd(0); rd(13);
    strobe(2'b00, 4'd7); strobe(2'b00, 4'd0);
    go("wrap_st", 0, 22, 4'd14, 1'b0);
    check("st_mem", mem[10], 8'h07);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
